uart_alu_host: RTL and testbench
================================

Name: uart_alu_host

Overview:
- Command initiator for the UART ALU protocol; the host-side end of the link served by the on-board ALU responder.
- Accepts one 32-bit two-operand command over a valid/ready interface and serializes it as a 12-byte request packet onto a byte-stream TX port.
- Collects the 4-byte result from a byte-stream RX port, then presents it on a valid/ready response port.
- Sits between a stimulus/controller and a uart_tx/uart_rx pair, for loopback self-test and board-to-board use.

Parameters:
- datawidth_p, 8, byte width of the TX/RX streams; fixed at 8.
- timeout_cycles_p, 33000000, maximum idle cycles between response bytes before the transaction is aborted (1 s at 33 MHz).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  block can accept a command
- cmd_opcode_i  in  8  ALU opcode byte
- cmd_a_i  in  32  operand A
- cmd_b_i  in  32  operand B
- tx_data_o  out  8  request byte to UART transmitter
- tx_valid_o  out  1  tx_data_o valid
- tx_ready_i  in  1  transmitter accepts byte
- rx_data_i  in  8  byte from UART receiver
- rx_valid_i  in  1  single-cycle strobe, rx_data_i valid
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  consumer accepts response
- rsp_data_o  out  32  result, little-endian assembled
- rsp_timeout_o  out  1  qualifies rsp_valid_o: transaction aborted

Behaviour:
- Reset values: cmd_ready_o=1, tx_valid_o=0, tx_data_o=0, rsp_valid_o=0, rsp_data_o=0, rsp_timeout_o=0. State=IDLE, counters zero.
- Reset takes effect on the next edge from any state. A packet being sent is abandoned mid-byte with no flush.
- Request packet, 12 bytes in order:
  - opcode
  - 0x00
  - length LSB 0x0C
  - length MSB 0x00
  - A[7:0], A[15:8], A[23:16], A[31:24]
  - B[7:0], B[15:8], B[23:16], B[31:24]
- Command handshake:
  - The command is captured into internal registers when cmd_valid_i & cmd_ready_o.
  - cmd_ready_o=1 only in IDLE and drops the cycle after capture.
  - Inputs may change after capture without affecting the packet.
- States:
  - IDLE: cmd_ready_o=1. On capture -> SEND.
  - SEND: tx_valid_o=1 with the byte at index idx (0..11).
    - tx_data_o/tx_valid_o stay stable until tx_ready_i.
    - On tx_valid_o & tx_ready_i, idx increments.
    - At idx=11 accepted -> WAIT.
    - Minimum 12 cycles if tx_ready_i is held high. First byte is presented the cycle after capture.
  - WAIT: collects 4 response bytes on rx_valid_i, LSB first, into rsp_data_o bits [8k+7:8k] for k=0..3.
    - Idle counter clears on entry and on each rx byte, and increments otherwise.
    - 4th byte -> RESP with rsp_timeout_o=0. rsp_valid_o is asserted the cycle after the 4th strobe.
    - Counter reaching timeout_cycles_p-1 with no byte -> RESP with rsp_timeout_o=1 and rsp_data_o=0; partial bytes are discarded.
  - RESP: rsp_valid_o=1, data stable until rsp_ready_i. On handshake -> IDLE; cmd_ready_o=1 the following cycle.
- rx bytes arriving in IDLE, SEND or RESP are dropped and never shift into the result.
- rx_valid_i in the same cycle the timeout fires: the byte is counted and the timeout does not fire.
- Only one transaction is outstanding; no pipelining.
- The opcode value is not interpreted; every opcode expects exactly 4 response bytes.

Test Plan:
- Add, instant response:
  - Stimulus: opcode 0xA1, A=0x00000005, B=0x00000007; tx_ready_i held 1.
  - TX bytes: A1 00 0C 00 05 00 00 00 07 00 00 00 on 12 consecutive cycles.
  - Then feed rx 0C 00 00 00: rsp_data_o=0x0000000C, rsp_timeout_o=0.
- TX backpressure:
  - Stimulus: tx_ready_i toggled 1/0 each cycle, A=0xDEADBEEF.
  - No byte duplicated or skipped.
  - tx_data_o is held while ready=0; bytes 4-7 are EF BE AD DE.
- Response assembly with gaps:
  - Stimulus: rx bytes 78,56,34,12 spaced 100 cycles apart, timeout_cycles_p=1000.
  - rsp_data_o=0x12345678; rsp_valid_o is held until rsp_ready_i, across 5 stall cycles.
- Timeout:
  - Stimulus: timeout_cycles_p=50; send 2 rx bytes, then silence.
  - rsp_valid_o with rsp_timeout_o=1 and rsp_data_o=0, exactly 50 cycles after the last byte.
  - The next command is accepted afterwards.
- Stray RX and new command:
  - Stimulus: rx bytes during IDLE and SEND; cmd_valid_i held high during SEND and WAIT.
  - Stray bytes are ignored.
  - cmd_ready_o stays 0 until the response handshake; the second command starts only after that.
- Reset mid-transaction:
  - Stimulus: rst_i asserted after byte 6 of a request.
  - All outputs return to reset values on the next edge.
  - A fresh command then emits a full 12-byte packet starting with its opcode.

Source files
------------

// File: rtl/uart_alu_host.sv
// Host-side initiator for the UART ALU link: serializes a two-operand command
// into a 12-byte request packet on the TX byte stream, then gathers the 4-byte
// little-endian result from the RX byte stream and offers it as a response.
// An idle watchdog in the response phase aborts a stalled transaction.
module uart_alu_host #(
  parameter int datawidth_p      = 8,
  parameter int timeout_cycles_p = 33000000
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [7:0]             cmd_opcode_i,
  input  logic [31:0]            cmd_a_i,
  input  logic [31:0]            cmd_b_i,
  output logic [datawidth_p-1:0] tx_data_o,
  output logic                   tx_valid_o,
  input  logic                   tx_ready_i,
  input  logic [datawidth_p-1:0] rx_data_i,
  input  logic                   rx_valid_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [31:0]            rsp_data_o,
  output logic                   rsp_timeout_o
);

  // Counter only needs to reach timeout_cycles_p-1.
  localparam int CNT_W = (timeout_cycles_p > 1) ? $clog2(timeout_cycles_p) : 1;
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(timeout_cycles_p - 1);
  localparam logic [3:0] LAST_IDX = 4'd11;

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT, ST_RESP} state_e;

  state_e           state_q, state_d;
  logic [7:0]       opcode_q, opcode_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [3:0]       idx_q, idx_d;
  logic [1:0]       rx_cnt_q, rx_cnt_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [23:0]      acc_q, acc_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             tx_valid_q, tx_valid_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic             rsp_timeout_q, rsp_timeout_d;

  // Byte at position idx of the request: opcode, 0x00, length 0x000C, A LE, B LE.
  function automatic logic [7:0] pkt_byte(input logic [3:0] idx, input logic [7:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [7:0] r;
    case (idx)
      4'd0:    r = op;
      4'd1:    r = 8'h00;
      4'd2:    r = 8'h0C;
      4'd3:    r = 8'h00;
      4'd4:    r = a[7:0];
      4'd5:    r = a[15:8];
      4'd6:    r = a[23:16];
      4'd7:    r = a[31:24];
      4'd8:    r = b[7:0];
      4'd9:    r = b[15:8];
      4'd10:   r = b[23:16];
      4'd11:   r = b[31:24];
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Next-state and registered-output computation for the transaction FSM.
  always_comb begin
    state_d       = state_q;
    opcode_d      = opcode_q;
    a_d           = a_q;
    b_d           = b_q;
    idx_d         = idx_q;
    rx_cnt_d      = rx_cnt_q;
    idle_cnt_d    = idle_cnt_q;
    acc_d         = acc_q;
    cmd_ready_d   = cmd_ready_q;
    tx_valid_d    = tx_valid_q;
    tx_data_d     = tx_data_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i && cmd_ready_q) begin
          opcode_d    = cmd_opcode_i;
          a_d         = cmd_a_i;
          b_d         = cmd_b_i;
          idx_d       = 4'd0;
          tx_data_d   = cmd_opcode_i;
          tx_valid_d  = 1'b1;
          cmd_ready_d = 1'b0;
          state_d     = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_ready_i) begin
          if (idx_q == LAST_IDX) begin
            tx_valid_d = 1'b0;
            idle_cnt_d = '0;
            rx_cnt_d   = 2'd0;
            acc_d      = '0;
            state_d    = ST_WAIT;
          end else begin
            idx_d     = idx_q + 4'd1;
            tx_data_d = pkt_byte(idx_q + 4'd1, opcode_q, a_q, b_q);
          end
        end
      end
      ST_WAIT: begin
        // A byte arriving on the expiry cycle wins over the timeout.
        if (rx_valid_i) begin
          idle_cnt_d = '0;
          rx_cnt_d   = rx_cnt_q + 2'd1;
          case (rx_cnt_q)
            2'd0: acc_d[7:0]   = rx_data_i;
            2'd1: acc_d[15:8]  = rx_data_i;
            2'd2: acc_d[23:16] = rx_data_i;
            default: begin
              rsp_data_d    = {rx_data_i, acc_q};
              rsp_valid_d   = 1'b1;
              rsp_timeout_d = 1'b0;
              state_d       = ST_RESP;
            end
          endcase
        end else if (idle_cnt_q == IDLE_LAST) begin
          rsp_data_d    = '0;
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = ST_RESP;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; operand/accumulator registers carry no reset.
  always_ff @(posedge clk_i) begin
    opcode_q <= opcode_d;
    a_q      <= a_d;
    b_q      <= b_d;
    acc_q    <= acc_d;
    if (rst_i) begin
      state_q       <= ST_IDLE;
      idx_q         <= 4'd0;
      rx_cnt_q      <= 2'd0;
      idle_cnt_q    <= '0;
      cmd_ready_q   <= 1'b1;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= 8'h00;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= 32'h0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      rx_cnt_q      <= rx_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      cmd_ready_q   <= cmd_ready_d;
      tx_valid_q    <= tx_valid_d;
      tx_data_q     <= tx_data_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready_o   = cmd_ready_q;
  assign tx_valid_o    = tx_valid_q;
  assign tx_data_o     = tx_data_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_data_o    = rsp_data_q;
  assign rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_uart_alu_host.sv
// Directed bench for uart_alu_host. Two instances share the stimulus: one with
// a 1000-cycle response timeout, one with 50. The instance not selected is held
// in reset, and the observed outputs are muxed from the selected one.
module tb_uart_alu_host;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        cmd_valid;
  logic [7:0]  cmd_opcode;
  logic [31:0] cmd_a, cmd_b;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rsp_ready;

  logic        a_cmd_ready, a_tx_valid, a_rsp_valid, a_rsp_timeout;
  logic [7:0]  a_tx_data;
  logic [31:0] a_rsp_data;
  logic        b_cmd_ready, b_tx_valid, b_rsp_valid, b_rsp_timeout;
  logic [7:0]  b_tx_data;
  logic [31:0] b_rsp_data;

  logic        cmd_ready, tx_valid, rsp_valid, rsp_timeout;
  logic [7:0]  tx_data;
  logic [31:0] rsp_data;
  logic        a_rst, b_rst;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign a_rst       = rst | sel;
  assign b_rst       = rst | ~sel;
  assign cmd_ready   = sel ? b_cmd_ready   : a_cmd_ready;
  assign tx_valid    = sel ? b_tx_valid    : a_tx_valid;
  assign tx_data     = sel ? b_tx_data     : a_tx_data;
  assign rsp_valid   = sel ? b_rsp_valid   : a_rsp_valid;
  assign rsp_data    = sel ? b_rsp_data    : a_rsp_data;
  assign rsp_timeout = sel ? b_rsp_timeout : a_rsp_timeout;

  uart_alu_host #(.datawidth_p(8), .timeout_cycles_p(1000)) u_dut_long (
    .clk_i(clk), .rst_i(a_rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(a_cmd_ready),
    .cmd_opcode_i(cmd_opcode), .cmd_a_i(cmd_a), .cmd_b_i(cmd_b),
    .tx_data_o(a_tx_data), .tx_valid_o(a_tx_valid), .tx_ready_i(tx_ready),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .rsp_valid_o(a_rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(a_rsp_data), .rsp_timeout_o(a_rsp_timeout)
  );

  uart_alu_host #(.datawidth_p(8), .timeout_cycles_p(50)) u_dut_short (
    .clk_i(clk), .rst_i(b_rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(b_cmd_ready),
    .cmd_opcode_i(cmd_opcode), .cmd_a_i(cmd_a), .cmd_b_i(cmd_b),
    .tx_data_o(b_tx_data), .tx_valid_o(b_tx_valid), .tx_ready_i(tx_ready),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(b_rsp_data), .rsp_timeout_o(b_rsp_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    while (!cmd_ready && n < 100) begin
      tick();
      n++;
    end
    chk("cmd_ready_before_send", {31'd0, cmd_ready}, 32'd1);
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    cmd_a      = a;
    cmd_b      = b;
    tick();
    cmd_valid  = 1'b0;
    cmd_opcode = 8'hFF;
    cmd_a      = 32'hFFFF_FFFF;
    cmd_b      = 32'hFFFF_FFFF;
  endtask

  // Walk the 12 request bytes; exp holds byte i at bits [8i+7:8i].
  task automatic tx_collect(input logic [95:0] exp, input bit toggle, output int cyc);
    int  i;
    bit  rdy;
    i   = 0;
    cyc = 0;
    rdy = 1'b1;
    while (i < 12 && cyc < 200) begin
      tx_ready = toggle ? rdy : 1'b1;
      chk("tx_valid", {31'd0, tx_valid}, 32'd1);
      chk("tx_byte", {24'd0, tx_data}, {24'd0, exp[8*i +: 8]});
      if (tx_ready) i++;
      tick();
      cyc++;
      rdy = ~rdy;
    end
    tx_ready = 1'b0;
    chk("tx_all_bytes", i, 32'd12);
    chk("tx_valid_after_pkt", {31'd0, tx_valid}, 32'd0);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic rsp_handshake(input logic [31:0] exp_data, input logic exp_to);
    chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rsp_data", rsp_data, exp_data);
    chk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, exp_to});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_valid_after_hs", {31'd0, rsp_valid}, 32'd0);
    chk("cmd_ready_after_hs", {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no_finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int n;
    rst = 1'b1; sel = 1'b0; cmd_valid = 1'b0; cmd_opcode = 8'h00;
    cmd_a = 32'h0; cmd_b = 32'h0; tx_ready = 1'b0; rx_data = 8'h00;
    rx_valid = 1'b0; rsp_ready = 1'b0;
    repeat (3) tick();

    // Reset values
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
    rst = 1'b0;
    tick();

    // Add, instant response: bytes A1 00 0C 00 05 00 00 00 07 00 00 00
    send_cmd(8'hA1, 32'h0000_0005, 32'h0000_0007);
    chk("t1_cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
    tx_collect(96'h00000007_00000005_000C00A1, 1'b0, cyc);
    chk("t1_tx_cycles", cyc, 32'd12);
    rx_byte(8'h0C); rx_byte(8'h00); rx_byte(8'h00);
    chk("t1_rsp_early", {31'd0, rsp_valid}, 32'd0);
    rx_byte(8'h00);
    rsp_handshake(32'h0000_000C, 1'b0);

    // TX backpressure: ready toggles, bytes 4-7 EF BE AD DE
    send_cmd(8'h3C, 32'hDEAD_BEEF, 32'h0102_0304);
    tx_collect(96'h01020304_DEADBEEF_000C003C, 1'b1, cyc);
    chk("t2_tx_cycles", cyc, 32'd23);
    rx_byte(8'h11); rx_byte(8'h22); rx_byte(8'h33); rx_byte(8'h44);
    rsp_handshake(32'h4433_2211, 1'b0);

    // Response with 100-cycle gaps, then 5 stall cycles on rsp_ready
    send_cmd(8'h07, 32'h1111_2222, 32'h3333_4444);
    tx_collect(96'h33334444_11112222_000C0007, 1'b0, cyc);
    rx_byte(8'h78); repeat (99) tick();
    rx_byte(8'h56); repeat (99) tick();
    rx_byte(8'h34); repeat (99) tick();
    chk("t3_rsp_early", {31'd0, rsp_valid}, 32'd0);
    rx_byte(8'h12);
    for (int k = 0; k < 5; k++) begin
      chk("t3_hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("t3_hold_data", rsp_data, 32'h1234_5678);
      tick();
    end
    rsp_handshake(32'h1234_5678, 1'b0);

    // Timeout (50-cycle instance): two bytes, then silence
    sel = 1'b1;
    tick();
    send_cmd(8'hC3, 32'h0000_00AA, 32'h0000_00BB);
    tx_collect(96'h000000BB_000000AA_000C00C3, 1'b0, cyc);
    rx_byte(8'hAA); rx_byte(8'hBB);
    n = 0;
    while (!rsp_valid && n < 200) begin
      tick();
      n++;
    end
    chk("t4_timeout_latency", n, 32'd50);
    rsp_handshake(32'h0000_0000, 1'b1);
    // Next command; each byte arrives on the final cycle before expiry
    send_cmd(8'h55, 32'h0A0B_0C0D, 32'h0E0F_1011);
    tx_collect(96'h0E0F1011_0A0B0C0D_000C0055, 1'b0, cyc);
    rx_byte(8'hEF); repeat (49) tick();
    rx_byte(8'hBE); repeat (49) tick();
    rx_byte(8'hAD); repeat (49) tick();
    chk("t4_no_early_timeout", {31'd0, rsp_valid}, 32'd0);
    rx_byte(8'hDE);
    rsp_handshake(32'hDEAD_BEEF, 1'b0);

    // Stray RX and held cmd_valid
    sel = 1'b0;
    tick();
    rx_byte(8'h99); rx_byte(8'h98);
    chk("t5_idle_stray_rsp", {31'd0, rsp_valid}, 32'd0);
    cmd_valid = 1'b1; cmd_opcode = 8'h11; cmd_a = 32'h1; cmd_b = 32'h2;
    tick();
    cmd_opcode = 8'h22; cmd_a = 32'h3; cmd_b = 32'h4;
    rx_data = 8'hEE; rx_valid = 1'b1;
    tx_collect(96'h00000002_00000001_000C0011, 1'b0, cyc);
    rx_valid = 1'b0;
    chk("t5_cmd_ready_wait", {31'd0, cmd_ready}, 32'd0);
    rx_byte(8'h01); rx_byte(8'h02); rx_byte(8'h03); rx_byte(8'h04);
    chk("t5_cmd_ready_resp", {31'd0, cmd_ready}, 32'd0);
    chk("t5_rsp_data", rsp_data, 32'h0403_0201);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("t5_cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    chk("t5_no_tx_yet", {31'd0, tx_valid}, 32'd0);
    tick();
    cmd_valid = 1'b0;
    tx_collect(96'h00000004_00000003_000C0022, 1'b0, cyc);
    rx_byte(8'hAB); rx_byte(8'hCD); rx_byte(8'hEF); rx_byte(8'h01);
    rsp_handshake(32'h01EF_CDAB, 1'b0);

    // Reset mid-transaction after byte 6 is presented
    send_cmd(8'h77, 32'h1122_3344, 32'h5566_7788);
    tx_ready = 1'b1;
    repeat (6) tick();
    chk("t6_byte6", {24'd0, tx_data}, 32'h0000_0022);
    rst = 1'b1;
    tick();
    chk("t6_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("t6_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("t6_tx_data", {24'd0, tx_data}, 32'd0);
    chk("t6_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("t6_rsp_data", rsp_data, 32'd0);
    chk("t6_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
    rst = 1'b0;
    tx_ready = 1'b0;
    tick();
    send_cmd(8'h5A, 32'hCAFE_F00D, 32'h0BAD_BEEF);
    tx_collect(96'h0BADBEEF_CAFEF00D_000C005A, 1'b0, cyc);
    chk("t6_tx_cycles", cyc, 32'd12);
    rx_byte(8'h0D); rx_byte(8'hF0); rx_byte(8'hFE); rx_byte(8'hCA);
    rsp_handshake(32'hCAFE_F00D, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
